wdata_chan_mngr: RTL and testbench
==================================

WDATA_CHAN_MNGR -- requirements
Module: wdata_chan_mngr

Interface
REQ-001 The block SHALL have one clock and one reset; the reset SHALL be synchronous and active-high.
REQ-002 The block SHALL provide these ports:
- clk  input  1  : clock; all state changes on the rising edge.
- rst  input  1  : synchronous, active-high reset.
- next_mrq  input  1  : burst request; accepted when next_mrq & mreq_ready.
- mreq_ready  output  1  : request can be accepted this cycle.
- wdat_m_data  input  128  : line to send; beat n = bits [32n+31:32n].
- wdat_m_len  input  2  : beats-1 (0 = 1 beat ... 3 = 4 beats).
- wvalid  output  1  : write data valid.
- wready  input  1  : subordinate ready.
- wdata  output  32  : write data beat.
- wlast  output  1  : final beat of the burst.
- finish_mwd  output  1  : one-cycle pulse after the last beat handshake.
- wdat_m_busy  output  1  : a burst is in progress or pending.

Function
REQ-003 States: WDAT_MIDLE and WDAT_MSEND; any other encoding SHALL go to WDAT_MIDLE on the next cycle.
REQ-004 On an accepted request, wdat_m_data and wdat_m_len SHALL be captured into the active buffer, and the beat counter SHALL be cleared to 0.
- From WDAT_MIDLE, the state SHALL go to WDAT_MSEND.
- wvalid SHALL first assert the cycle after acceptance (latency 1).
REQ-005 In WDAT_MSEND:
- wvalid SHALL be 1.
- wdata SHALL be active-buffer beat[counter].
- wlast SHALL be (counter == captured len).
REQ-006 In WDAT_MIDLE, wvalid, wlast and wdata SHALL be 0.
REQ-007 A beat completes on wvalid & wready; the counter SHALL then increment by 1 (2-bit, no wrap needed since counter ≤ len).
REQ-008 Once wvalid is asserted, wvalid, wdata and wlast SHALL remain stable until the handshake; wvalid SHALL NOT depend combinationally on wready.
REQ-009 When the wlast beat completes with no pending request, the state SHALL return to WDAT_MIDLE.
REQ-010 finish_mwd SHALL pulse for exactly one cycle, the cycle after each wlast handshake.
REQ-011 When wready is held low, the current beat SHALL be held indefinitely, with no timeout.
REQ-012 wdat_m_busy SHALL be (state == WDAT_MSEND) | pending-valid.
REQ-013 next_mrq asserted while mreq_ready=0 SHALL be ignored; the requester SHALL hold its request.

Reset
REQ-014 While rst=1, the following SHALL apply at the next edge:
- state = WDAT_MIDLE, counter = 0.
- Active and pending buffers = 0; pending-valid = 0.
- Outputs wvalid, wlast, wdata, finish_mwd and wdat_m_busy = 0.
- mreq_ready = 1.
REQ-015 Reset asserted mid-burst SHALL abandon the burst and SHALL NOT produce a finish_mwd pulse; the first request after reset SHALL start at beat 0.

Configuration
REQ-016 Macro WDAT_M_PENDQ_EN SHALL select a one-entry pending request queue.
REQ-017 Without WDAT_M_PENDQ_EN: mreq_ready = (state == WDAT_MIDLE), and consecutive bursts SHALL be separated by at least one idle cycle.
REQ-018 With WDAT_M_PENDQ_EN: mreq_ready = ~pending-valid.
- An accept in WDAT_MIDLE SHALL load the active buffer.
- An accept in WDAT_MSEND SHALL load the pending entry.
REQ-019 With WDAT_M_PENDQ_EN, on a wlast handshake with pending-valid=1:
- The pending entry SHALL move to the active buffer, the counter SHALL be cleared, and pending-valid SHALL clear.
- The state SHALL stay WDAT_MSEND, so the next burst's beat 0 is driven the following cycle with no gap.
REQ-020 With WDAT_M_PENDQ_EN, on a wlast handshake coinciding with an accept while pending-valid=0, the request SHALL load the active buffer directly and the state SHALL stay WDAT_MSEND.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Basic burst: request with data 0x44444444_33333333_22222222_11111111, len=3, wready=1. Required: wdata 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles; wlast only on 0x44444444; finish_mwd one cycle later.
- Single beat: len=0, data[31:0]=0xDEADBEEF. Required: one beat with wlast=1, then return to WDAT_MIDLE.
- Backpressure: len=3, wready low 3 cycles at beat 1. Required: wdata held at beat 1 with wvalid=1 throughout, then completes in order.
- Queued request (macro on): second request, len=1 with data[63:0]=0xBBBBBBBB_AAAAAAAA, accepted mid-burst. Required: its first beat 0xAAAAAAAA the cycle after the first burst's wlast handshake; two finish_mwd pulses.
- Queue disabled (macro off): request during WDAT_MSEND. Required: mreq_ready=0 until the wlast handshake completes.
- Reset mid-burst: rst at beat 2. Required: wvalid=0 and finish_mwd=0 next cycle; the next request starts at beat 0.

Source files
------------

// File: rtl/wdata_chan_mngr.sv
// Write-data channel manager: serialises a captured 128-bit line into 1-4 32-bit beats.
// Optional one-entry pending request queue enabled by WDAT_M_PENDQ_EN.
module wdata_chan_mngr (
  input  logic         clk,
  input  logic         rst,
  input  logic         next_mrq,
  output logic         mreq_ready,
  input  logic [127:0] wdat_m_data,
  input  logic [1:0]   wdat_m_len,
  output logic         wvalid,
  input  logic         wready,
  output logic [31:0]  wdata,
  output logic         wlast,
  output logic         finish_mwd,
  output logic         wdat_m_busy
);

  typedef enum logic [1:0] {
    WDAT_MIDLE = 2'b00,
    WDAT_MSEND = 2'b01
  } state_t;

  state_t       state, state_nxt;
  logic [127:0] act_data;
  logic [1:0]   act_len;
  logic [1:0]   cnt;
  logic         sending, accept, beat_hs, last_hs, load_act;

`ifdef WDAT_M_PENDQ_EN
  logic [127:0] pend_data;
  logic [1:0]   pend_len;
  logic         pend_vld;
  logic         load_pend, promote;
`endif

  // Beat outputs derive only from registered state, so they hold until the handshake.
  assign sending = (state == WDAT_MSEND);
  assign wvalid  = sending;
  assign wdata   = sending ? act_data[{cnt, 5'd0} +: 32] : 32'd0;
  assign wlast   = sending && (cnt == act_len);
  assign beat_hs = wvalid & wready;
  assign last_hs = beat_hs & wlast;
  assign accept  = next_mrq & mreq_ready;

`ifdef WDAT_M_PENDQ_EN
  assign mreq_ready  = ~pend_vld;
  assign wdat_m_busy = sending | pend_vld;
`else
  assign mreq_ready  = (state == WDAT_MIDLE);
  assign wdat_m_busy = sending;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= WDAT_MIDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_act  = 1'b0;
`ifdef WDAT_M_PENDQ_EN
    load_pend = 1'b0;
    promote   = 1'b0;
`endif
    case (state)
      WDAT_MIDLE: begin
        if (accept) begin
          load_act  = 1'b1;
          state_nxt = WDAT_MSEND;
        end
      end
      WDAT_MSEND: begin
`ifdef WDAT_M_PENDQ_EN
        // pend_vld blocks accept, so promote and accept never coincide.
        if (last_hs && pend_vld)    promote   = 1'b1;
        else if (last_hs && accept) load_act  = 1'b1;
        else if (accept)            load_pend = 1'b1;
        else if (last_hs)           state_nxt = WDAT_MIDLE;
`else
        if (last_hs) state_nxt = WDAT_MIDLE;
`endif
      end
      default: state_nxt = WDAT_MIDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_data   <= '0;
      act_len    <= '0;
      cnt        <= '0;
      finish_mwd <= 1'b0;
    end else begin
      finish_mwd <= last_hs;
      if (load_act) begin
        act_data <= wdat_m_data;
        act_len  <= wdat_m_len;
        cnt      <= '0;
      end
`ifdef WDAT_M_PENDQ_EN
      else if (promote) begin
        act_data <= pend_data;
        act_len  <= pend_len;
        cnt      <= '0;
      end
`endif
      else if (beat_hs) begin
        cnt <= cnt + 2'd1;
      end
    end
  end

`ifdef WDAT_M_PENDQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_data <= '0;
      pend_len  <= '0;
      pend_vld  <= 1'b0;
    end else if (load_pend) begin
      pend_data <= wdat_m_data;
      pend_len  <= wdat_m_len;
      pend_vld  <= 1'b1;
    end else if (promote) begin
      pend_vld  <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_wdata_chan_mngr.sv
// Directed bench for wdata_chan_mngr: vector table plus hand-written multi-cycle sequences.
module tb_wdata_chan_mngr;

`ifdef WDAT_M_PENDQ_EN
  localparam logic Q = 1'b1;
`else
  localparam logic Q = 1'b0;
`endif

  localparam logic [127:0] D1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] D2 = 128'h0000000F_0000000E_0000000D_DEADBEEF;
  localparam logic [127:0] D3 = 128'h44440000_33330000_22220000_11110000;
  localparam logic [127:0] D4 = 128'h0000000C_0000000B_BBBBBBBB_AAAAAAAA;

  logic         clk = 1'b0;
  logic         rst, next_mrq, mreq_ready, wvalid, wready, wlast, finish_mwd, wdat_m_busy;
  logic [127:0] wdat_m_data;
  logic [1:0]   wdat_m_len;
  logic [31:0]  wdata;

  int total = 0;
  int bad   = 0;
  int fin_cnt;

  always #5 clk = ~clk;

  wdata_chan_mngr dut (
    .clk(clk), .rst(rst), .next_mrq(next_mrq), .mreq_ready(mreq_ready),
    .wdat_m_data(wdat_m_data), .wdat_m_len(wdat_m_len), .wvalid(wvalid),
    .wready(wready), .wdata(wdata), .wlast(wlast), .finish_mwd(finish_mwd),
    .wdat_m_busy(wdat_m_busy)
  );

  typedef struct {
    logic         rst, req, wr;
    logic [1:0]   len;
    logic [127:0] dat;
    logic         rdy, vld;
    logic [31:0]  wd;
    logic         wl, fin, busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic q, input logic w, input logic [1:0] l,
                     input logic [127:0] d, input logic rdy, input logic vld,
                     input logic [31:0] wd, input logic wl, input logic fin, input logic busy);
    vec_t v;
    v.rst = r; v.req = q; v.wr = w; v.len = l; v.dat = d;
    v.rdy = rdy; v.vld = vld; v.wd = wd; v.wl = wl; v.fin = fin; v.busy = busy;
    tbl.push_back(v);
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic cyc(input logic r, input logic q, input logic w,
                     input logic [1:0] l, input logic [127:0] d);
    @(negedge clk);
    rst = r; next_mrq = q; wready = w; wdat_m_len = l; wdat_m_data = d;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic vld,
                         input logic [31:0] wd, input logic wl, input logic fin, input logic busy);
    chk({tag, ".mreq_ready"}, {31'd0, mreq_ready}, {31'd0, rdy});
    chk({tag, ".wvalid"},     {31'd0, wvalid},     {31'd0, vld});
    chk({tag, ".wdata"},      wdata,               wd);
    chk({tag, ".wlast"},      {31'd0, wlast},      {31'd0, wl});
    chk({tag, ".finish"},     {31'd0, finish_mwd}, {31'd0, fin});
    chk({tag, ".busy"},       {31'd0, wdat_m_busy},{31'd0, busy});
  endtask

  initial begin
    rst = 1'b1; next_mrq = 1'b0; wready = 1'b1; wdat_m_len = 2'd0; wdat_m_data = '0;

    // Reset idle, basic 4-beat burst
    add(0,0,1,0,0,   1,0,32'h0,0,0,0);
    add(0,1,1,3,D1,  1,0,32'h0,0,0,0);
    add(0,0,1,0,0,   Q,1,32'h11111111,0,0,1);
    add(0,0,1,0,0,   Q,1,32'h22222222,0,0,1);
    add(0,0,1,0,0,   Q,1,32'h33333333,0,0,1);
    add(0,0,1,0,0,   Q,1,32'h44444444,1,0,1);
    add(0,0,1,0,0,   1,0,32'h0,0,1,0);
    add(0,0,1,0,0,   1,0,32'h0,0,0,0);
    // Single beat
    add(0,1,1,0,D2,  1,0,32'h0,0,0,0);
    add(0,0,1,0,0,   Q,1,32'hDEADBEEF,1,0,1);
    add(0,0,1,0,0,   1,0,32'h0,0,1,0);
    // Backpressure at beat 1 for 3 cycles
    add(0,1,1,3,D1,  1,0,32'h0,0,0,0);
    add(0,0,1,0,0,   Q,1,32'h11111111,0,0,1);
    add(0,0,0,0,0,   Q,1,32'h22222222,0,0,1);
    add(0,0,0,0,0,   Q,1,32'h22222222,0,0,1);
    add(0,0,0,0,0,   Q,1,32'h22222222,0,0,1);
    add(0,0,1,0,0,   Q,1,32'h22222222,0,0,1);
    add(0,0,1,0,0,   Q,1,32'h33333333,0,0,1);
    add(0,0,1,0,0,   Q,1,32'h44444444,1,0,1);
    add(0,0,1,0,0,   1,0,32'h0,0,1,0);
    add(0,0,1,0,0,   1,0,32'h0,0,0,0);

    cyc(1,0,1,0,0);
    cyc(1,0,1,0,0);
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rst, tbl[i].req, tbl[i].wr, tbl[i].len, tbl[i].dat);
      chk_all($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].vld, tbl[i].wd,
              tbl[i].wl, tbl[i].fin, tbl[i].busy);
    end

    // Reset during beat 2 abandons the burst silently
    cyc(0,1,1,3,D1);
    cyc(0,0,1,0,0);
    cyc(0,0,1,0,0);
    cyc(1,0,1,0,0);
    chk("rst.pre_wdata", wdata, 32'h33333333);
    cyc(0,1,1,0,D3);
    chk_all("rst.after", 1,0,32'h0,0,0,0);
    cyc(0,0,1,0,0);
    chk_all("rst.restart", Q,1,32'h11110000,1,0,1);
    cyc(0,0,1,0,0);
    chk_all("rst.done", 1,0,32'h0,0,1,0);

`ifdef WDAT_M_PENDQ_EN
    // Second request queued mid-burst follows with no gap
    fin_cnt = 0;
    cyc(0,1,1,3,D1);
    cyc(0,1,1,1,D4);
    chk_all("q.beat0", 1,1,32'h11111111,0,0,1);
    cyc(0,0,1,0,0);
    chk_all("q.beat1", 0,1,32'h22222222,0,0,1);
    cyc(0,0,1,0,0);
    chk("q.beat2", wdata, 32'h33333333);
    cyc(0,0,1,0,0);
    chk_all("q.beat3", 0,1,32'h44444444,1,0,1);
    cyc(0,0,1,0,0);
    fin_cnt += int'(finish_mwd);
    chk_all("q.b2beat0", 1,1,32'hAAAAAAAA,0,1,1);
    cyc(0,0,1,0,0);
    fin_cnt += int'(finish_mwd);
    chk_all("q.b2beat1", 1,1,32'hBBBBBBBB,1,0,1);
    cyc(0,0,1,0,0);
    fin_cnt += int'(finish_mwd);
    chk_all("q.idle", 1,0,32'h0,0,1,0);
    cyc(0,0,1,0,0);
    fin_cnt += int'(finish_mwd);
    chk("q.fin_pulses", fin_cnt, 2);
`else
    // Without the queue a request during a burst waits for the wlast handshake
    cyc(0,1,1,1,D4);
    cyc(0,1,1,3,D1);
    chk_all("nq.beat0", 0,1,32'hAAAAAAAA,0,0,1);
    cyc(0,1,1,3,D1);
    chk_all("nq.beat1", 0,1,32'hBBBBBBBB,1,0,1);
    cyc(0,1,1,3,D1);
    chk_all("nq.gap", 1,0,32'h0,0,1,0);
    cyc(0,0,1,0,0);
    chk_all("nq.next0", 0,1,32'h11111111,0,0,1);
    cyc(0,0,1,0,0);
    cyc(0,0,1,0,0);
    cyc(0,0,1,0,0);
    chk("nq.next3", wdata, 32'h44444444);
    cyc(0,0,1,0,0);
    chk_all("nq.done", 1,0,32'h0,0,1,0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
